// File: rtl/pc_out_wrr_arbiter.sv
// Weighted round-robin arbiter: three word sources share one registered 32-bit
// output stage; each grant allows a burst of up to the source's weight words.
module pc_out_wrr_arbiter #(
    parameter int unsigned N  = 32,
    parameter int unsigned NW = 4,
    parameter int unsigned NS = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NS*N-1:0] in_d,
    input  logic [NS-1:0]   in_v,
    output logic [NS-1:0]   in_a,
    output logic [N-1:0]    out_d,
    output logic            out_v,
    input  logic            out_a,
    input  logic [NS*NW-1:0] weights,
    output logic [1:0]      cur_grant,
    output logic            busy
);

    localparam int unsigned GW = 2;
    localparam logic [GW-1:0] NO_GRANT = GW'(3);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   g_q, g_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [NW-1:0]   credit_q, credit_d;
    logic [N-1:0]    out_d_q, out_d_d;
    logic            out_v_q, out_v_d;

    logic [N-1:0]    src_d [NS];
    logic [NW-1:0]   src_w [NS];

    // Unpack the flat source buses so they can be indexed by grant number.
    for (genvar i = 0; i < NS; i++) begin : g_unpack
        assign src_d[i] = in_d[i*N +: N];
        assign src_w[i] = weights[i*NW +: NW];
    end

    function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
        return (idx == GW'(2)) ? GW'(0) : idx + GW'(1);
    endfunction

    logic            out_xfer;
    logic            ack;
    logic            in_xfer;
    logic            found;
    logic [GW-1:0]   pick;
    logic [GW-1:0]   scan;

    // Next-state, datapath and combinational source ack.
    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        rr_d     = rr_q;
        credit_d = credit_q;
        out_d_d  = out_d_q;
        out_v_d  = out_v_q;
        in_a     = '0;
        ack      = 1'b0;
        in_xfer  = 1'b0;
        found    = 1'b0;
        pick     = '0;
        scan     = rr_q;
        out_xfer = out_v_q && out_a;

        unique case (state_q)
            IDLE: begin
                if (out_xfer) begin
                    out_v_d = 1'b0;
                end
                // First valid, enabled source starting at the round-robin pointer.
                for (int k = 0; k < 3; k++) begin
                    if (!found && in_v[scan] && (src_w[scan] != '0)) begin
                        found = 1'b1;
                        pick  = scan;
                    end
                    scan = next_idx(scan);
                end
                if (found) begin
                    state_d  = GRANT;
                    g_d      = pick;
                    credit_d = src_w[pick];
                end
            end

            GRANT: begin
                ack        = !out_v_q || out_a;
                in_a[g_q]  = ack;
                in_xfer    = in_v[g_q] && ack;
                if (in_xfer) begin
                    out_d_d  = src_d[g_q];
                    out_v_d  = 1'b1;
                    credit_d = credit_q - NW'(1);
                    if (credit_q == NW'(1)) begin
                        state_d = IDLE;
                        rr_d    = next_idx(g_q);
                    end
                end else begin
                    if (out_xfer) begin
                        out_v_d = 1'b0;
                    end
                    if (!in_v[g_q]) begin
                        state_d = IDLE;
                        rr_d    = next_idx(g_q);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            g_q      <= '0;
            rr_q     <= '0;
            credit_q <= '0;
            out_d_q  <= '0;
            out_v_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            rr_q     <= rr_d;
            credit_q <= credit_d;
            out_d_q  <= out_d_d;
            out_v_q  <= out_v_d;
        end
    end

    assign out_d     = out_d_q;
    assign out_v     = out_v_q;
    assign busy      = (state_q == GRANT);
    assign cur_grant = (state_q == GRANT) ? g_q : NO_GRANT;

endmodule

// File: tb/tb_pc_out_wrr_arbiter.sv
// Bench for pc_out_wrr_arbiter: per-cycle vector table of inputs and expected
// control outputs, with a word scoreboard checking output data order.
module tb_pc_out_wrr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] in_d;
    logic [2:0]  in_v;
    logic [2:0]  in_a;
    logic [31:0] out_d;
    logic        out_v;
    logic        out_a;
    logic [11:0] weights;
    logic [1:0]  cur_grant;
    logic        busy;

    pc_out_wrr_arbiter #(.N(32), .NW(4), .NS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_d      (in_d),
        .in_v      (in_v),
        .in_a      (in_a),
        .out_d     (out_d),
        .out_v     (out_v),
        .out_a     (out_a),
        .weights   (weights),
        .cur_grant (cur_grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  v;
        logic [11:0] w;
        logic        oa;
        logic [1:0]  g;
        logic        ov;
        logic        chk;
        logic        d0;
        logic        tally;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb[$];
    int          seq[3];
    int          acc[3];
    int          n_chk = 0;
    int          n_err = 0;

    task automatic add(input logic rst, input logic [2:0] v, input logic [11:0] w,
                       input logic oa, input logic [1:0] g, input logic ov,
                       input logic chk, input logic d0, input logic tally);
        vec_t r;
        r.rst = rst; r.v = v; r.w = w; r.oa = oa; r.g = g; r.ov = ov;
        r.chk = chk; r.d0 = d0; r.tally = tally;
        tbl.push_back(r);
    endtask

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row=%0d got=%0h expected=%0h", name, row, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int src, input int n);
        return {8'(src), 24'(n)};
    endfunction

    initial begin
        int ga[9] = '{3, 0, 0, 3, 1, 3, 2, 2, 2};
        int oa9[9] = '{1, 0, 1, 1, 0, 1, 0, 1, 1};
        int gb[5] = '{3, 1, 1, 1, 1};
        int ob[5] = '{1, 0, 1, 1, 1};
        int gc[6] = '{3, 2, 2, 2, 2, 2};
        int oc[6] = '{1, 0, 1, 1, 1, 1};

        reset = 1'b1; in_v = '0; weights = '0; out_a = 1'b0; in_d = '0;
        for (int i = 0; i < 3; i++) begin seq[i] = 0; acc[i] = 0; end

        // Reset; the first row has no defined state yet.
        add(1, 3'b111, 12'h312, 1, 3, 0, 0, 0, 0);
        add(1, 3'b111, 12'h312, 1, 3, 0, 1, 1, 0);
        // Weights (2,1,3), all valid: 4 rotations of 9 cycles.
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 9; k++)
                add(0, 3'b111, 12'h312, 1, 2'(ga[k]),
                    (p == 0 && k == 0) ? 1'b0 : 1'(oa9[k]), 1, 0, 1);
        // Only source 1 valid, weights 4: bursts of 4 with a bubble.
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 5; k++)
                add(0, 3'b010, 12'h444, 1, 2'(gb[k]), 1'(ob[k]), 1, 0, 0);
        // Source 0 disabled by weight 0.
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 6; k++)
                add(0, 3'b101, 12'h550, 1, 2'(gc[k]), 1'(oc[k]), 1, 0, 0);
        // Backpressure for 5 cycles after the first word of a 3-word burst.
        add(0, 3'b001, 12'h333, 1, 3, 1, 1, 0, 0);
        add(0, 3'b001, 12'h333, 1, 0, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++)
            add(0, 3'b001, 12'h333, 0, 0, 1, 1, 0, 0);
        add(0, 3'b001, 12'h333, 1, 0, 1, 1, 0, 0);
        add(0, 3'b001, 12'h333, 1, 0, 1, 1, 0, 0);
        // Weight raised to 7 mid-burst, then source 0 drops valid after one word.
        add(0, 3'b001, 12'h333, 1, 3, 1, 1, 0, 0);
        add(0, 3'b001, 12'h337, 1, 0, 0, 1, 0, 0);
        add(0, 3'b001, 12'h337, 1, 0, 1, 1, 0, 0);
        add(0, 3'b001, 12'h337, 1, 0, 1, 1, 0, 0);
        add(0, 3'b001, 12'h333, 1, 3, 1, 1, 0, 0);
        add(0, 3'b001, 12'h333, 1, 0, 0, 1, 0, 0);
        add(0, 3'b010, 12'h333, 1, 0, 1, 1, 0, 0);
        add(0, 3'b010, 12'h333, 1, 3, 0, 1, 0, 0);
        add(0, 3'b010, 12'h333, 1, 1, 0, 1, 0, 0);
        add(0, 3'b010, 12'h333, 1, 1, 1, 1, 0, 0);
        // Reset mid-grant with a held word, then lowest valid source wins.
        add(1, 3'b011, 12'h333, 0, 1, 1, 1, 0, 0);
        add(0, 3'b011, 12'h333, 1, 3, 0, 1, 1, 0);
        add(0, 3'b011, 12'h333, 1, 0, 0, 1, 0, 0);
        add(0, 3'b011, 12'h333, 1, 0, 1, 1, 0, 0);
        add(0, 3'b011, 12'h333, 1, 0, 1, 1, 0, 0);
        // All weights zero: no grant, output drains.
        add(0, 3'b111, 12'h000, 1, 3, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++)
            add(0, 3'b111, 12'h000, 1, 3, 0, 1, 0, 0);

        for (int row = 0; row < tbl.size(); row++) begin
            vec_t        r;
            logic [2:0]  exp_a;
            r = tbl[row];
            @(negedge clk);
            reset = r.rst; in_v = r.v; weights = r.w; out_a = r.oa;
            for (int i = 0; i < 3; i++) in_d[i*32 +: 32] = word_of(i, seq[i]);
            #1;
            exp_a = '0;
            if (r.g != 2'd3 && (!r.ov || r.oa)) exp_a[r.g] = 1'b1;
            if (r.chk) begin
                check("cur_grant", row, 32'(cur_grant), 32'(r.g));
                check("in_a", row, 32'(in_a), 32'(exp_a));
                check("out_v", row, 32'(out_v), 32'(r.ov));
                check("busy", row, 32'(busy), 32'(r.g != 2'd3));
                if (r.d0) check("out_d_reset", row, out_d, 32'h0);
                if (r.ov) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", row, 32'(1), 32'(0));
                    end else begin
                        check("out_d", row, out_d, sb[0]);
                        if (r.oa) void'(sb.pop_front());
                    end
                end
                if (r.tally)
                    for (int i = 0; i < 3; i++) acc[i] += int'(in_v[i] & in_a[i]);
                for (int i = 0; i < 3; i++) begin
                    if (exp_a[i] && r.v[i]) begin
                        sb.push_back(word_of(i, seq[i]));
                        seq[i]++;
                    end
                end
            end
            if (r.rst) sb.delete();
        end

        check("ratio_src0", -1, 32'(acc[0]), 32'd8);
        check("ratio_src1", -1, 32'(acc[1]), 32'd4);
        check("ratio_src2", -1, 32'(acc[2]), 32'd12);
        check("sb_left", -1, 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
